// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus: memory address/data, control inputs and the
// valid/ready decode stage. The fetch unit is the master side.
interface instr_fetch_unit_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_next;
    logic        fetch_fault;
    logic [15:0] fetch_count;

    // Handshake: a word moves on every cycle where out_valid && out_ready;
    // while out_valid && !out_ready, if_instr/if_pc/if_pc_next stay stable.
    modport master (
        output imem_addr, out_valid, if_instr, if_pc, if_pc_next,
               fetch_fault, fetch_count,
        input  imem_instr, stall, redirect_valid, redirect_target, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, if_instr, if_pc, if_pc_next,
               fetch_fault, fetch_count,
        output imem_instr, stall, redirect_valid, redirect_target, out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter owner: fetches big-endian words from a combinational
// instruction memory into a registered valid/ready stage for decode.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd2,
    parameter int          MEM_BYTES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instr_fetch_unit_if.master       bus,
    output logic [1:0]               state_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic        out_valid_q;
    logic [15:0] if_instr_q;
    logic [15:0] if_pc_q;
    logic [15:0] if_pc_next_q;
    logic        fetch_fault_q;
    logic [15:0] fetch_count_q;

    logic [16:0] pc_plus1_d;
    logic        in_range_d;
    logic        accept_d;
    logic        load_d;
    logic [15:0] pc_inc_d;

    // 17-bit compare so pc=16'hFFFF cannot wrap into range.
    assign pc_plus1_d = {1'b0, pc_q} + 17'd1;
    assign in_range_d = pc_plus1_d < 17'(MEM_BYTES);
    assign pc_inc_d   = pc_q + PC_STEP;
    assign accept_d   = out_valid_q && bus.out_ready;
    assign load_d     = (state_q == ST_RUN) && !bus.stall &&
                        (!out_valid_q || bus.out_ready) &&
                        !bus.redirect_valid && in_range_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            if_instr_q    <= 16'h0000;
            if_pc_q       <= 16'h0000;
            if_pc_next_q  <= 16'h0000;
            fetch_fault_q <= 1'b0;
            fetch_count_q <= 16'h0000;
        end else begin
            // A handshake on the redirect cycle still counts: it completes before the squash.
            if (accept_d) fetch_count_q <= fetch_count_q + 16'd1;

            if (bus.redirect_valid) begin
                pc_q          <= bus.redirect_target;
                out_valid_q   <= 1'b0;
                fetch_fault_q <= 1'b0;
                state_q       <= ST_RUN;
            end else begin
                case (state_q)
                    ST_BOOT: state_q <= ST_RUN;
                    ST_RUN: begin
                        if (load_d) begin
                            if_instr_q   <= bus.imem_instr;
                            if_pc_q      <= pc_q;
                            if_pc_next_q <= pc_inc_d;
                            out_valid_q  <= 1'b1;
                            pc_q         <= pc_inc_d;
                        end else if (bus.out_ready) begin
                            out_valid_q  <= 1'b0;
                        end
                        if (!in_range_d) begin
                            fetch_fault_q <= 1'b1;
                            state_q       <= ST_FAULT;
                        end
                    end
                    ST_FAULT: begin
                        if (bus.out_ready) out_valid_q <= 1'b0;
                    end
                    default: state_q <= ST_BOOT;
                endcase
            end
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_pc_next  = if_pc_next_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.fetch_count = fetch_count_q;
    assign state_o         = state_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reader/initiator side of the instruction-memory interface.
- Owns the program counter and drives a 16-bit byte address to the combinational instruction memory. The memory returns the big-endian 16-bit word: byte[addr] in [15:8], byte[addr+1] in [7:0].
- Registers each fetched word into a valid/ready output stage for decode.
- Handles stall, branch/jump redirect, and out-of-range fault.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per sequential fetch.
- MEM_BYTES, 256, size of the instruction memory in bytes; a fetch is legal only if pc+1 < MEM_BYTES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_addr  output  16  byte address to instruction memory; always equals pc
- imem_instr  input  16  instruction word returned combinationally for imem_addr
- stall  input  1  hazard stall; when high, no new fetch is captured and pc holds
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_target  input  16  new byte address; odd values are legal
- out_valid  output  1  if_instr/if_pc hold a valid instruction
- out_ready  input  1  decode accepts the instruction this cycle
- if_instr  output  16  registered instruction
- if_pc  output  16  byte address that if_instr was fetched from
- if_pc_next  output  16  if_pc + PC_STEP, mod 2^16 (registered)
- fetch_fault  output  1  sticky out-of-range fetch flag
- fetch_count  output  16  number of accepted handshakes (out_valid & out_ready), wraps mod 2^16

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=BOOT; out_valid=0; if_instr=0; if_pc=0; if_pc_next=0; fetch_fault=0; fetch_count=0. Reset asserted mid-operation discards everything immediately.
- States: BOOT, RUN, FAULT.
- BOOT:
  - Exactly one cycle after rst_n deasserts; out_valid=0; pc holds.
  - -> RUN unconditionally, unless redirect_valid, which loads pc then -> RUN.
- RUN:
  - load = !stall && (!out_valid || out_ready) && !redirect_valid && in_range.
  - in_range = (pc + 1 < MEM_BYTES), evaluated with 17-bit arithmetic so pc=16'hFFFF is out of range.
  - On load: if_instr<=imem_instr; if_pc<=pc; if_pc_next<=pc+PC_STEP; out_valid<=1; pc<=pc+PC_STEP (wraps mod 2^16).
  - Not load, out_valid && !out_ready: all output registers hold. This is the back-pressure rule: data must be stable while valid && !ready.
  - Not load, out_ready high: out_valid<=0 (bubble). This covers stall and fault cases.
  - Fetch-to-output latency: 1 cycle (address presented in cycle N, instruction visible at out_valid in cycle N+1).
  - !in_range && !redirect_valid: fetch_fault<=1; -> FAULT; a pending valid output still completes its handshake normally.
- Redirect (any state, highest priority after reset):
  - pc<=redirect_target; out_valid<=0 next cycle (the in-flight instruction is squashed even if out_ready is low); fetch_fault<=0; -> RUN.
  - The first fetch from the target is captured on the following cycle, subject to stall/ready.
  - redirect_valid and stall simultaneously: the redirect is taken; stall only blocks the next fetch.
- FAULT:
  - No fetches; pc holds; out_valid drops once the pending instruction is accepted.
  - Exits only via redirect or reset.
- fetch_count increments on every cycle with out_valid && out_ready, including the cycle a redirect arrives (the handshake completes before the squash).
- imem_addr = pc combinationally; no other combinational path from inputs to outputs.

Test Plan:
- Sequential fetch: reset, memory word at 0x0000 = 16'h0000 and at 0x0002 = 16'h0001; out_ready=1, stall=0 -> cycle 2 after reset: out_valid=1, if_pc=0x0000, if_instr=0x0000; next cycle: if_pc=0x0002, if_instr=0x0001, if_pc_next=0x0004; fetch_count increments by 1 per cycle.
- Back-pressure: hold out_ready=0 for 3 cycles with out_valid=1, if_pc=0x0004 -> if_instr/if_pc unchanged, pc stays 0x0006, fetch_count frozen; release -> 0x0006 delivered on the next cycle.
- Stall: stall=1 for 2 cycles with out_ready=1 -> out_valid=0 for 2 cycles, pc frozen, no instruction skipped.
- Redirect to odd address: redirect_valid=1, target=0x0011, while out_valid=1, out_ready=0 -> next cycle out_valid=0; following cycle if_pc=0x0011, if_instr={mem[0x11],mem[0x12]}, if_pc_next=0x0013.
- Fault: redirect to 0x00FE -> word fetched normally, pc=0x0100 -> fetch_fault=1, out_valid=0 after the handshake, no further fetches; redirect to 0x0000 clears fetch_fault and resumes.
- Async reset mid-stream: drop rst_n between clock edges while out_valid=1 -> out_valid, fetch_count, fetch_fault go to 0 immediately and pc=RESET_PC; one BOOT bubble after release.
